// File: rtl/bit_serial_add_ctrl.sv
// Word-level sequencer around an external bit-serial full adder.
// Latches two operands, clears the adder carry, streams operand bits
// LSB-first, reassembles the serial sum and captures the final carry.
module bit_serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             ser_clear,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             ser_s,
  input  logic             ser_cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    CARRY = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_sh_reg, a_sh_next;
  logic [WIDTH-1:0]   b_sh_reg, b_sh_next;
  logic [WIDTH-1:0]   sum_reg, sum_next;
  logic [WIDTH-1:0]   sum_shifted;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               carry_reg, carry_next;
  logic               done_reg, done_next;

  // Sum register shifts right; the adder's sum bit enters at the MSB so
  // that after WIDTH shifts bit 0 of the operands lands at bit 0 of sum.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
      assign sum_shifted[gi] = sum_reg[gi+1];
    end
  endgenerate
  assign sum_shifted[WIDTH-1] = ser_s;

  // The adder carry is forced clear while reset is asserted as well as in
  // CLEAR, so an aborted operation never leaks a carry into the next one.
  assign ser_clear = reset | (state_reg == CLEAR);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign sum       = sum_reg;
  assign carry_out = carry_reg;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      sum_reg   <= sum_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      done_reg  <= done_next;
    end
  end

  // Next-state, datapath updates and serial outputs.
  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    sum_next   = sum_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    done_next  = 1'b0;
    ser_a      = 1'b0;
    ser_b      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_sh_next  = op_a;
          b_sh_next  = op_b;
          cnt_next   = '0;
          sum_next   = '0;
          carry_next = 1'b0;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        ser_a     = a_sh_reg[0];
        ser_b     = b_sh_reg[0];
        a_sh_next = a_sh_reg >> 1;
        b_sh_next = b_sh_reg >> 1;
        sum_next  = sum_shifted;
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          cnt_next   = '0;
          state_next = CARRY;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      CARRY: begin
        // Adder carry register now holds the carry out of bit WIDTH-1.
        carry_next = ser_cout;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench: two sequencer instances (8 and 16 bit), each with a
// behavioural bit-serial adder, checked through a queue of expected results.
module tb_bit_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // 8-bit instance
  logic        start8;
  logic [7:0]  op_a8, op_b8, sum8;
  logic        busy8, done8, cout8, ser_clear8, ser_a8, ser_b8, ser_s8, ser_cout8;
  // 16-bit instance
  logic        start16;
  logic [15:0] op_a16, op_b16, sum16;
  logic        busy16, done16, cout16, ser_clear16, ser_a16, ser_b16, ser_s16, ser_cout16;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt8  = 0;
  int done_cnt16 = 0;
  logic [8:0]  q8[$];
  logic [16:0] q16[$];

  bit_serial_add_ctrl #(.WIDTH(8), .CNT_W(5)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op_a(op_a8), .op_b(op_b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8),
    .ser_clear(ser_clear8), .ser_a(ser_a8), .ser_b(ser_b8),
    .ser_s(ser_s8), .ser_cout(ser_cout8)
  );

  bit_serial_add_ctrl #(.WIDTH(16), .CNT_W(5)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op_a(op_a16), .op_b(op_b16),
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(cout16),
    .ser_clear(ser_clear16), .ser_a(ser_a16), .ser_b(ser_b16),
    .ser_s(ser_s16), .ser_cout(ser_cout16)
  );

  // Behavioural bit-serial full adders: combinational sum, registered carry.
  logic c8, c16;
  assign ser_s8     = ser_a8 ^ ser_b8 ^ c8;
  assign ser_cout8  = c8;
  assign ser_s16    = ser_a16 ^ ser_b16 ^ c16;
  assign ser_cout16 = c16;
  always @(posedge clk) begin
    c8  <= ser_clear8  ? 1'b0 : ((ser_a8 & ser_b8) | (ser_a8 & c8) | (ser_b8 & c8));
    c16 <= ser_clear16 ? 1'b0 : ((ser_a16 & ser_b16) | (ser_a16 & c16) | (ser_b16 & c16));
  end

  // Count done pulses (one per high cycle).
  always @(posedge clk) begin
    if (done8 === 1'b1)  done_cnt8++;
    if (done16 === 1'b1) done_cnt16++;
  end

  // Drive one start cycle and record the expected result; returns one
  // cycle after the accepting edge (edge count n = 0).
  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; op_a8 = a; op_b8 = b;
    q8.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1; op_a16 = a; op_b16 = b;
    q16.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  // Bounded wait for done; n returns edges since the accepting edge.
  task automatic wait_done8(input int n0, output int n);
    n = n0;
    while (done8 !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_done16(input int n0, output int n);
    n = n0;
    while (done16 !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start8 = 1'b0; start16 = 1'b0;
    op_a8 = '0; op_b8 = '0; op_a16 = '0; op_b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy8, done8, sum8, cout8, ser_a8, ser_b8} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b a=%b b=%b, want all 0",
               busy8, done8, sum8, cout8, ser_a8, ser_b8);
    end
    n_cmp++;
    if (ser_clear8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ser_clear: got %b want 1", ser_clear8);
    end
    n_cmp++;
    if ({busy16, done16, sum16, cout16} !== 19'h0) begin
      n_fail++; $display("FAIL reset_state16: got busy=%b done=%b sum=%h cout=%b want 0",
                         busy16, done16, sum16, cout16);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (ser_clear8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_clear: got %b want 0", ser_clear8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int n, busy_cnt, clr_cnt, clr_at;
    logic [8:0] exp;
    issue8(8'd49, 8'd20);
    n = 0; busy_cnt = 0; clr_cnt = 0; clr_at = -1;
    while (done8 !== 1'b1 && n < 60) begin
      if (busy8 === 1'b1) busy_cnt++;
      if (ser_clear8 === 1'b1) begin clr_cnt++; clr_at = n; end
      if (n == 1) begin
        n_cmp++;
        if ({ser_a8, ser_b8} !== 2'b10) begin
          n_fail++; $display("FAIL basic_first_bits: got a=%b b=%b want a=1 b=0", ser_a8, ser_b8);
        end
      end
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (n !== 10) begin n_fail++; $display("FAIL basic_latency: got %0d edges want 10", n); end
    n_cmp++;
    if (busy_cnt !== 10) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 10", busy_cnt); end
    n_cmp++;
    if (clr_cnt !== 1 || clr_at !== 0) begin
      n_fail++; $display("FAIL basic_ser_clear: got %0d cycles at n=%0d want 1 at n=0", clr_cnt, clr_at);
    end
    exp = q8.pop_front();
    n_cmp++;
    if ({cout8, sum8} !== exp) begin
      n_fail++; $display("FAIL basic_result: got %h want %h", {cout8, sum8}, exp);
    end
    $display("txn basic 49+20 -> sum=%h cout=%b", sum8, cout8);
    @(posedge clk); #1;
    n_cmp++;
    if (done8 !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", done8); end
    n_cmp++;
    if ({cout8, sum8} !== exp) begin
      n_fail++; $display("FAIL basic_hold: got %h want %h", {cout8, sum8}, exp);
    end
  endtask

  task automatic test_carry_clear;
    int n;
    logic [8:0] exp;
    logic [7:0] av[2];
    logic [7:0] bv[2];
    av[0] = 8'hFF; bv[0] = 8'h01;
    av[1] = 8'h00; bv[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      issue8(av[k], bv[k]);
      wait_done8(0, n);
      n_cmp++;
      if (n !== 10) begin n_fail++; $display("FAIL carry_latency[%0d]: got %0d want 10", k, n); end
      exp = q8.pop_front();
      n_cmp++;
      if ({cout8, sum8} !== exp) begin
        n_fail++; $display("FAIL carry_result[%0d]: got %h want %h", k, {cout8, sum8}, exp);
      end
      $display("txn carry %h+%h -> sum=%h cout=%b", av[k], bv[k], sum8, cout8);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_while_busy;
    int n, d0;
    logic [8:0] exp;
    d0 = done_cnt8;
    issue8(8'h0F, 8'h01);
    n = 0;
    while (n < 7) begin
      if (n == 3) begin start8 = 1'b1; op_a8 = 8'hAA; op_b8 = 8'h55; end
      @(posedge clk); #1; n++;
    end
    start8 = 1'b0;
    wait_done8(n, n);
    n_cmp++;
    if (n !== 10) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 10", n); end
    exp = q8.pop_front();
    n_cmp++;
    if ({cout8, sum8} !== exp) begin
      n_fail++; $display("FAIL busy_start_result: got %h want %h", {cout8, sum8}, exp);
    end
    $display("txn busy_start 0F+01 -> sum=%h cout=%b", sum8, cout8);
    repeat (15) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt8 - d0 !== 1) begin
      n_fail++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt8 - d0);
    end
    n_cmp++;
    if (busy8 !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got busy=%b want 0", busy8); end
  endtask

  task automatic test_reset_mid;
    int n, d0;
    logic [8:0] exp;
    d0 = done_cnt8;
    issue8(8'h80, 8'h80);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ser_clear8 !== 1'b1) begin n_fail++; $display("FAIL midreset_clear: got %b want 1", ser_clear8); end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy8, done8, sum8, cout8} !== 11'h0) begin
      n_fail++; $display("FAIL midreset_state: got busy=%b done=%b sum=%h cout=%b want 0",
                         busy8, done8, sum8, cout8);
    end
    void'(q8.pop_back());
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt8 - d0 !== 0) begin
      n_fail++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_cnt8 - d0);
    end
    issue8(8'h03, 8'h04);
    wait_done8(0, n);
    exp = q8.pop_front();
    n_cmp++;
    if (n !== 10 || {cout8, sum8} !== exp) begin
      n_fail++; $display("FAIL midreset_after: got %h at n=%0d want %h at 10", {cout8, sum8}, n, exp);
    end
    $display("txn after_reset 03+04 -> sum=%h cout=%b", sum8, cout8);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    logic [8:0] exp;
    start8 = 1'b1; op_a8 = 8'h7F; op_b8 = 8'h01;
    q8.push_back({1'b0, op_a8} + {1'b0, op_b8});
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      wait_done8(0, n);
      n_cmp++;
      if (n !== 10) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want 10", k, n); end
      exp = q8.pop_front();
      n_cmp++;
      if ({cout8, sum8} !== exp) begin
        n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", k, {cout8, sum8}, exp);
      end
      $display("txn b2b[%0d] 7F+01 -> sum=%h cout=%b", k, sum8, cout8);
      if (k < 3) q8.push_back(9'h080);
      else start8 = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (k < 3) begin
        if ({done8, busy8, sum8} !== 10'b01_0000_0000) begin
          n_fail++; $display("FAIL b2b_restart[%0d]: got done=%b busy=%b sum=%h want 0 1 00",
                             k, done8, busy8, sum8);
        end
      end else begin
        if ({done8, busy8} !== 2'b00) begin
          n_fail++; $display("FAIL b2b_stop: got done=%b busy=%b want 0 0", done8, busy8);
        end
      end
    end
  endtask

  task automatic test_random;
    int n, d8, d16;
    logic [8:0]  e8;
    logic [16:0] e16;
    d8 = done_cnt8; d16 = done_cnt16;
    for (int k = 0; k < 200; k++) begin
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_done8(0, n);
      e8 = q8.pop_front();
      n_cmp++;
      if (n !== 10 || {cout8, sum8} !== e8) begin
        n_fail++; $display("FAIL rand8[%0d]: got %h at n=%0d want %h at 10", k, {cout8, sum8}, n, e8);
      end
      $display("txn rand8[%0d] %h+%h -> %h", k, op_a8, op_b8, {cout8, sum8});
      @(posedge clk); #1;
    end
    for (int k = 0; k < 200; k++) begin
      issue16(16'($urandom), 16'($urandom));
      wait_done16(0, n);
      e16 = q16.pop_front();
      n_cmp++;
      if (n !== 18 || {cout16, sum16} !== e16) begin
        n_fail++; $display("FAIL rand16[%0d]: got %h at n=%0d want %h at 18", k, {cout16, sum16}, n, e16);
      end
      $display("txn rand16[%0d] %h+%h -> %h", k, op_a16, op_b16, {cout16, sum16});
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done_cnt8 - d8 !== 200 || done_cnt16 - d16 !== 200) begin
      n_fail++; $display("FAIL rand_done_count: got %0d/%0d want 200/200", done_cnt8 - d8, done_cnt16 - d16);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_clear();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
